// File: rtl/integrator_scheduler_pkg.sv
// Shared types and helpers for the integrator scheduler: FSM encoding,
// the dt exponent shift, float32 constants and the combinational float32 add.
package integrator_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    // dt = 2^-10, applied by subtracting this from the exponent
    localparam logic [7:0]  DT_EXP_SHIFT = 8'd10;
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;

    // Combinational float32 add, round-to-nearest-even. Subnormal inputs and
    // results flush to signed zero; Inf/NaN operands propagate unchanged.
    function automatic logic [31:0] add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y, t;
        logic [7:0]        d;
        logic [26:0]       mx, my, sh;
        logic              sticky, sgn, rnd;
        logic [27:0]       s;
        logic signed [9:0] e;
        logic [23:0]       m;
        logic [24:0]       mr;
        begin
            x = a;
            y = b;
            if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
            if (x[30:23] == 8'd0) return y;
            if (y[30:23] == 8'd0) return x;
            if (x[30:23] == 8'hFF) return x;
            if (y[30:23] == 8'hFF) return y;
            // order operands so |x| >= |y|
            if (y[30:0] > x[30:0]) begin
                t = x;
                x = y;
                y = t;
            end
            d  = x[30:23] - y[30:23];
            mx = {1'b1, x[22:0], 3'b000};
            my = {1'b1, y[22:0], 3'b000};
            if (d >= 8'd27) begin
                sh     = 27'd0;
                sticky = 1'b1;
            end else begin
                sh     = my >> d;
                sticky = |(my & ((27'd1 << d) - 27'd1));
            end
            sh[0] = sh[0] | sticky;
            e     = $signed({2'b00, x[30:23]});
            sgn   = x[31];
            if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
            else                s = {1'b0, mx} - {1'b0, sh};
            // exact cancellation gives +0
            if (s == 28'd0) return 32'd0;
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 10'sd1;
            end else begin
                for (int i = 0; i < 26; i++) begin
                    if (!s[26]) begin
                        s = s << 1;
                        e = e - 10'sd1;
                    end
                end
            end
            m   = s[26:3];
            rnd = s[2] & (s[1] | s[0] | s[3]);
            mr  = {1'b0, m} + {24'd0, rnd};
            if (mr[24]) e = e + 10'sd1;
            if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
            if (e <= 10'sd0)   return {sgn, 31'd0};
            return {sgn, e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
        end
    endfunction

endpackage

// File: rtl/integrator_scheduler_step.sv
// Combinational Euler step: out = x*2^-10 + int_x in float32.
module integrator_step
    import integrator_scheduler_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] int_x,
    output logic [31:0] out
);
    logic [31:0] scaled;

    // Scale by dt via exponent subtract; small exponents contribute +0
    always_comb begin
        scaled = FP32_ZERO;
        if (x[30:23] > DT_EXP_SHIFT)
            scaled = {x[31], x[30:23] - DT_EXP_SHIFT, x[22:0]};
    end

    assign out = add(scaled, int_x);
endmodule

// File: rtl/integrator_scheduler.sv
// Time-multiplexed Euler integrator: on each tick, sweeps all channels,
// requesting each derivative and writing the integrated value back.
// Optional per-channel ack timeout: define INTEG_TIMEOUT_EN.
module integrator_scheduler
    import integrator_scheduler_pkg::*;
#(
    parameter int          N_CH       = 8,
    parameter int          IDX_W      = 3,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    output logic             deriv_req,
    output logic [IDX_W-1:0] deriv_idx,
    input  logic             deriv_ack,
    input  logic [31:0]      deriv_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             timeout_err
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    fsm_e             fsm;
    logic [IDX_W-1:0] ch;
    logic [31:0]      state [N_CH];
    logic [31:0]      step_out;
    logic             advance;
    logic             to_hit;
    logic             rd_ok;

    integrator_step u_step (
        .x     (deriv_data),
        .int_x (state[ch]),
        .out   (step_out)
    );

`ifdef INTEG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign to_hit = (fsm == S_REQ) && !deriv_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Per-channel wait counter, restarted whenever a channel is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (fsm == S_REQ && !advance) wait_cnt <= wait_cnt + 1'b1;
            else                          wait_cnt <= '0;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    // TIMEOUT has no effect without the timeout feature
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign to_hit         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign advance   = (fsm == S_REQ) && (deriv_ack || to_hit);
    assign deriv_req = (fsm == S_REQ);
    assign deriv_idx = ch;
    assign busy      = (fsm != S_IDLE);
    assign done      = (fsm == S_DONE);
    assign rd_ok     = ({{(32-IDX_W){1'b0}}, rd_idx} < 32'(N_CH));

    // Sweep FSM, state bank write-back, read port and overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= S_IDLE;
            ch      <= '0;
            overrun <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < N_CH; i++) state[i] <= INIT_VALUE;
        end else begin
            // read sees the pre-write value on a same-edge collision
            rd_data <= rd_ok ? state[rd_idx] : 32'd0;
            if (tick && fsm != S_IDLE) overrun <= 1'b1;
            case (fsm)
                S_IDLE: begin
                    if (tick) begin
                        fsm <= S_REQ;
                        ch  <= '0;
                    end
                end
                S_REQ: begin
                    if (deriv_ack) state[ch] <= step_out;
                    if (advance) begin
                        if (ch == LAST) fsm <= S_DONE;
                        else            ch  <= ch + 1'b1;
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_integrator_scheduler.sv
// Directed bench for integrator_scheduler (N_CH=8). Timeout checks are built
// only when INTEG_TIMEOUT_EN is defined.
module tb_integrator_scheduler;
    import integrator_scheduler_pkg::*;

    localparam int N_CH  = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset, tick, ack_drv, skip5;
    logic             deriv_req, deriv_ack, busy, done, overrun, timeout_err;
    logic [IDX_W-1:0] deriv_idx, rd_idx;
    logic [31:0]      deriv_data, rd_data;
    logic [31:0]      dtab [N_CH];
    int               cmp = 0;
    int               mis = 0;
    int               n;

    always #5 clk = ~clk;

    // Derivative producer: table lookup, optionally never acking channel 5
    assign deriv_ack  = ack_drv && !(skip5 && deriv_idx == 3'd5);
    assign deriv_data = dtab[deriv_idx];

    integrator_scheduler #(
        .N_CH(N_CH), .IDX_W(IDX_W), .INIT_VALUE(32'h0000_0000), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .deriv_req(deriv_req), .deriv_idx(deriv_idx),
        .deriv_ack(deriv_ack), .deriv_data(deriv_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .overrun(overrun), .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int idx, input logic [31:0] exp);
        rd_idx = IDX_W'(idx);
        step();
        chk($sformatf("state%0d", idx), rd_data, exp);
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < N_CH; i++) dtab[i] = v;
    endtask

    // Sweep with ack held high; cyc = cycle index (tick edge = 1) where done is seen
    task automatic sweep_fast(output int cyc);
        ack_drv = 1'b1;
        tick    = 1'b1;
        step();
        tick = 1'b0;
        cyc  = 1;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        ack_drv = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; ack_drv = 1'b0; skip5 = 1'b0; rd_idx = '0;
        set_all(FP32_ONE);
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_req", 32'(deriv_req), 32'd0);
        chk("rst_idx", 32'(deriv_idx), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        reset = 1'b0;
        rd(3, 32'h0000_0000);

        // Sweep A: all 1.0 -> 2^-10 everywhere, done 1+N_CH cycles after tick
        sweep_fast(n);
        chk("lat_A", 32'(n), 32'(N_CH + 1));
        chk("idle_A", 32'(busy), 32'd0);
        for (int i = 0; i < N_CH; i++) rd(i, 32'h3A80_0000);

        // Sweep B: -1.0 cancels ch2, exp=10 flushes on ch3, rest reach 2^-9
        dtab[2] = 32'hBF80_0000;
        dtab[3] = 32'h0500_0000;
        sweep_fast(n);
        chk("lat_B", 32'(n), 32'(N_CH + 1));
        for (int i = 0; i < N_CH; i++)
            rd(i, (i == 2) ? 32'h0000_0000 : (i == 3) ? 32'h3A80_0000 : 32'h3B00_0000);
        chk("overrun_B", 32'(overrun), 32'd0);

        // Stray acks while idle must not write
        set_all(FP32_ONE);
        dtab[2] = 32'h0580_0000;
        ack_drv = 1'b1;
        step(); step(); step();
        ack_drv = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        rd(0, 32'h3B00_0000);
        rd(2, 32'h0000_0000);

        // Sweep C: ack on the 4th cycle of each channel, extra tick at ch3
        tick = 1'b1;
        step();
        tick = 1'b0;
        n = busy ? 1 : 0;
        for (int c = 0; c < N_CH; c++) begin
            ack_drv = 1'b0;
            if (c == 3) tick = 1'b1;
            step();
            tick = 1'b0;
            if (busy) n++;
            step(); if (busy) n++;
            step(); if (busy) n++;
            ack_drv = 1'b1;
            step(); if (busy) n++;
        end
        ack_drv = 1'b0;
        chk("done_C", 32'(done), 32'd1);
        step();
        chk("idle_C", 32'(busy), 32'd0);
        chk("len_C", 32'(n), 32'(4 * N_CH + 1));
        chk("overrun_C", 32'(overrun), 32'd1);
        for (int i = 0; i < N_CH; i++)
            rd(i, (i == 2) ? 32'h0080_0000 : (i == 3) ? 32'h3B00_0000 : 32'h3B40_0000);

        // Reset in the middle of a sweep at ch=4, then a late ack
        set_all(FP32_ONE);
        ack_drv = 1'b1;
        tick    = 1'b1;
        step();
        tick = 1'b0;
        n = 0;
        while (deriv_idx != 3'd4 && n < 20) begin
            step();
            n++;
        end
        chk("mid_idx", 32'(deriv_idx), 32'd4);
        reset = 1'b1;
        step();
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_req", 32'(deriv_req), 32'd0);
        chk("mid_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step(); step();
        chk("late_busy", 32'(busy), 32'd0);
        ack_drv = 1'b0;
        for (int i = 0; i < N_CH; i++) rd(i, 32'h0000_0000);

`ifdef INTEG_TIMEOUT_EN
        // Channel 5 never acks: skipped after 16 cycles, others updated
        skip5 = 1'b1;
        sweep_fast(n);
        skip5 = 1'b0;
        chk("lat_TO", 32'(n), 32'(5 + 16 + 2 + 1));
        chk("timeout_err", 32'(timeout_err), 32'd1);
        for (int i = 0; i < N_CH; i++)
            rd(i, (i == 5) ? 32'h0000_0000 : 32'h3A80_0000);
`else
        chk("timeout_off", 32'(timeout_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
